// File: rtl/pattern_response_misr_if.sv
// Response-compaction bus: the harness drives run control, response samples and
// the golden signature; the MISR reports run status, signature and sample count.
interface pattern_response_misr_if #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 7
);
  logic             start;
  logic             abort;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_in;
  logic [WIDTH-1:0] golden;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    output start, abort, resp_valid, resp_in, golden,
    input  busy, done, pass, signature, sample_cnt
  );

  modport slave (
    input  start, abort, resp_valid, resp_in, golden,
    output busy, done, pass, signature, sample_cnt
  );
endinterface

// File: rtl/pattern_response_misr.sv
// Response compaction for the pattern stage: folds WINDOW valid response
// vectors into a Galois MISR, then compares the signature against golden.
// All outputs come straight from flops.
module pattern_response_misr #(
  parameter int               WIDTH  = 9,
  parameter int               WINDOW = 64,
  parameter int               CNT_W  = 7,
  parameter logic [WIDTH-1:0] POLY   = 9'h011,
  parameter logic [WIDTH-1:0] SEED   = 9'h000
) (
  input logic                     blif_clk_net,
  input logic                     blif_reset_net,
  pattern_response_misr_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // One Galois MISR step: shift up, fold the dropped MSB back through POLY,
  // then XOR in the new response vector.
  function automatic logic [WIDTH-1:0] misr_step(
    input logic [WIDTH-1:0] sig,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] fb;
    fb = sig[WIDTH-1] ? POLY : {WIDTH{1'b0}};
    misr_step = {sig[WIDTH-2:0], 1'b0} ^ fb ^ din;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] sig_r;
  logic [WIDTH-1:0] sig_next_s;
  logic [WIDTH-1:0] sig_step_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             pass_r;
  logic             pass_next_s;
  logic             busy_r;
  logic             done_r;

  assign sig_step_s = misr_step(sig_r, bus.resp_in);

  // Next-state and datapath update; abort outranks both sampling and restart.
  always_comb begin
    state_next_s = state_r;
    sig_next_s   = sig_r;
    cnt_next_s   = cnt_r;
    pass_next_s  = pass_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next_s = ST_RUN;
          sig_next_s   = SEED;
          cnt_next_s   = CNT_ZERO;
          pass_next_s  = 1'b0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          // Run discarded: signature and count stay visible for debug.
          state_next_s = ST_IDLE;
          pass_next_s  = 1'b0;
        end else if (bus.resp_valid) begin
          sig_next_s = sig_step_s;
          cnt_next_s = cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_next_s = ST_DONE;
            pass_next_s  = (sig_step_s == bus.golden);
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          state_next_s = ST_IDLE;
          pass_next_s  = 1'b0;
        end else if (bus.start) begin
          state_next_s = ST_RUN;
          sig_next_s   = SEED;
          cnt_next_s   = CNT_ZERO;
          pass_next_s  = 1'b0;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        // Unused encoding recovers to a clean idle.
        state_next_s = ST_IDLE;
        sig_next_s   = SEED;
        cnt_next_s   = CNT_ZERO;
        pass_next_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and status flops; status flags are decoded from the next state
  // so busy/done line up with the state they describe.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state_r <= ST_IDLE;
      sig_r   <= SEED;
      cnt_r   <= CNT_ZERO;
      pass_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      sig_r   <= sig_next_s;
      cnt_r   <= cnt_next_s;
      pass_r  <= pass_next_s;
      busy_r  <= (state_next_s == ST_RUN);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.signature  = sig_r;
  assign bus.sample_cnt = cnt_r;

endmodule

// File: tb/tb_pattern_response_misr.sv
// Bench for pattern_response_misr: two instances (WINDOW=64 and WINDOW=2) share
// one stimulus stream and are checked every cycle against a polynomial-arithmetic
// reference model, plus a hand-computed vector table and directed corner cases.
module tb_pattern_response_misr;

  localparam int WIDTH = 9;
  localparam int CNT_W = 7;

  logic clk;
  logic rst_n;

  pattern_response_misr_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) a_if ();
  pattern_response_misr_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) b_if ();

  pattern_response_misr #(.WIDTH(WIDTH), .WINDOW(64), .CNT_W(CNT_W),
                          .POLY(9'h011), .SEED(9'h000)) dut_a (
    .blif_clk_net(clk), .blif_reset_net(rst_n), .bus(a_if.slave));

  pattern_response_misr #(.WIDTH(WIDTH), .WINDOW(2), .CNT_W(CNT_W),
                          .POLY(9'h011), .SEED(9'h000)) dut_b (
    .blif_clk_net(clk), .blif_reset_net(rst_n), .bus(b_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle 1=run 2=done; signature kept as a polynomial
  // over GF(2) reduced modulo x^9+x^4+1 (0x211).
  int m_mode [2];
  int m_sig  [2];
  int m_cnt  [2];
  int m_pass [2];
  int m_win  [2] = '{64, 2};

  function automatic int gf_absorb(int s, int d);
    int t;
    t = s * 2;
    if (t >= 512) t = t ^ 'h211;
    return t ^ d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_sig[k] = 0; m_cnt[k] = 0; m_pass[k] = 0;
    end
  endtask

  task automatic model_step(int k, bit st, bit ab, bit v, int r, int g);
    case (m_mode[k])
      0: if (st && !ab) begin m_mode[k] = 1; m_sig[k] = 0; m_cnt[k] = 0; m_pass[k] = 0; end
      1: begin
        if (ab) begin
          m_mode[k] = 0; m_pass[k] = 0;
        end else if (v) begin
          m_sig[k] = gf_absorb(m_sig[k], r);
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == m_win[k]) begin
            m_mode[k] = 2; m_pass[k] = (m_sig[k] == g) ? 1 : 0;
          end
        end
      end
      default: begin
        if (ab) begin
          m_mode[k] = 0; m_pass[k] = 0;
        end else if (st) begin
          m_mode[k] = 1; m_sig[k] = 0; m_cnt[k] = 0; m_pass[k] = 0;
        end
      end
    endcase
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("a.busy", 32'(a_if.busy), 32'(m_mode[0] == 1));
    chk("a.done", 32'(a_if.done), 32'(m_mode[0] == 2));
    chk("a.pass", 32'(a_if.pass), 32'(m_pass[0]));
    chk("a.sig",  32'(a_if.signature), 32'(m_sig[0]));
    chk("a.cnt",  32'(a_if.sample_cnt), 32'(m_cnt[0]));
    chk("b.busy", 32'(b_if.busy), 32'(m_mode[1] == 1));
    chk("b.done", 32'(b_if.done), 32'(m_mode[1] == 2));
    chk("b.pass", 32'(b_if.pass), 32'(m_pass[1]));
    chk("b.sig",  32'(b_if.signature), 32'(m_sig[1]));
    chk("b.cnt",  32'(b_if.sample_cnt), 32'(m_cnt[1]));
  endtask

  // Apply one cycle of stimulus to both instances, advance the model, then
  // compare just after the edge.
  task automatic drive(bit st, bit ab, bit v, int r, int g);
    a_if.start = st; a_if.abort = ab; a_if.resp_valid = v;
    a_if.resp_in = 9'(r); a_if.golden = 9'(g);
    b_if.start = st; b_if.abort = ab; b_if.resp_valid = v;
    b_if.resp_in = 9'(r); b_if.golden = 9'(g);
    for (int k = 0; k < 2; k++) model_step(k, st, ab, v, r, g);
    @(posedge clk);
    #1;
    check_models();
  endtask

  typedef struct {
    bit st; bit ab; bit v; int r; int g;
    bit busy; bit done; bit pass; int sig; int cnt;
  } vec_t;

  vec_t tbl [15];
  int   saved_sig;

  initial begin
    // Hand-computed expectations for the WINDOW=2 instance.
    tbl[0]  = '{1, 0, 0, 'h000, 'h011, 1, 0, 0, 'h000, 0};
    tbl[1]  = '{0, 0, 1, 'h100, 'h011, 1, 0, 0, 'h100, 1};
    tbl[2]  = '{0, 0, 1, 'h000, 'h011, 0, 1, 1, 'h011, 2};
    tbl[3]  = '{0, 0, 1, 'h1ff, 'h011, 0, 1, 1, 'h011, 2};
    tbl[4]  = '{1, 0, 1, 'h0aa, 'h010, 1, 0, 0, 'h000, 0};
    tbl[5]  = '{0, 0, 1, 'h100, 'h010, 1, 0, 0, 'h100, 1};
    tbl[6]  = '{1, 0, 0, 'h055, 'h010, 1, 0, 0, 'h100, 1};
    tbl[7]  = '{0, 0, 1, 'h000, 'h010, 0, 1, 0, 'h011, 2};
    tbl[8]  = '{0, 1, 0, 'h000, 'h010, 0, 0, 0, 'h011, 2};
    tbl[9]  = '{1, 0, 0, 'h000, 'h000, 1, 0, 0, 'h000, 0};
    tbl[10] = '{0, 0, 1, 'h001, 'h000, 1, 0, 0, 'h001, 1};
    tbl[11] = '{0, 0, 0, 'h1ff, 'h000, 1, 0, 0, 'h001, 1};
    tbl[12] = '{0, 0, 0, 'h0f0, 'h000, 1, 0, 0, 'h001, 1};
    tbl[13] = '{0, 0, 1, 'h002, 'h000, 0, 1, 1, 'h000, 2};
    tbl[14] = '{0, 0, 0, 'h000, 'h000, 0, 1, 1, 'h000, 2};

    rst_n = 1'b0;
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.resp_valid = 1'b0;
    a_if.resp_in = '0; a_if.golden = '0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.resp_valid = 1'b0;
    b_if.resp_in = '0; b_if.golden = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_models();
    @(negedge clk);
    rst_n = 1'b1;

    // Table: feedback path, DONE hold, restart, ignored start, abort, gapped valid.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].st, tbl[i].ab, tbl[i].v, tbl[i].r, tbl[i].g);
      chk($sformatf("tbl%0d.busy", i), 32'(b_if.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i), 32'(b_if.done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d.pass", i), 32'(b_if.pass), 32'(tbl[i].pass));
      chk($sformatf("tbl%0d.sig", i),  32'(b_if.signature), 32'(tbl[i].sig));
      chk($sformatf("tbl%0d.cnt", i),  32'(b_if.sample_cnt), 32'(tbl[i].cnt));
    end

    // Zero response over the full 64-sample window.
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 63; i++) drive(0, 0, 1, 0, 0);
    chk("zero.busy63", 32'(a_if.busy), 32'd1);
    chk("zero.done63", 32'(a_if.done), 32'd0);
    drive(0, 0, 1, 0, 0);
    chk("zero.done", 32'(a_if.done), 32'd1);
    chk("zero.pass", 32'(a_if.pass), 32'd1);
    chk("zero.sig",  32'(a_if.signature), 32'h000);
    chk("zero.cnt",  32'(a_if.sample_cnt), 32'd64);

    // Abort with valid and start at sample_cnt=5.
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, int'($urandom_range(0, 511)), 0);
    saved_sig = m_sig[0];
    drive(1, 1, 1, 'h1a5, 0);
    chk("abort.busy", 32'(a_if.busy), 32'd0);
    chk("abort.cnt",  32'(a_if.sample_cnt), 32'd5);
    chk("abort.sig",  32'(a_if.signature), 32'(saved_sig));
    chk("abort.pass", 32'(a_if.pass), 32'd0);

    // Asynchronous reset mid-run after 10 samples, sampled between edges.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, int'($urandom_range(1, 511)), 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.busy", 32'(a_if.busy), 32'd0);
    chk("rst.done", 32'(a_if.done), 32'd0);
    chk("rst.pass", 32'(a_if.pass), 32'd0);
    chk("rst.sig",  32'(a_if.signature), 32'h000);
    chk("rst.cnt",  32'(a_if.sample_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 'h0ff, 0);
    drive(0, 0, 1, 'h0ff, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 70), int'($urandom_range(0, 511)),
            int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
